// File: rtl/if_spi_video_rd_if.sv
// Command, SPI and message-source signals of the SBIS video readout master.
// The master modport is the readout block's view of the bundle.
interface if_spi_video_rd_if;
  logic [7:0] in_data;
  logic       in_ena;
  logic       n_cs;
  logic       sclk;
  logic       miso;
  logic       have_msg;
  logic [7:0] len;
  logic [7:0] out_data;
  logic       enc_rdreq;

  modport master (
    input  in_data, in_ena, miso, enc_rdreq,
    output n_cs, sclk, have_msg, len, out_data
  );

  modport slave (
    output in_data, in_ena, miso, enc_rdreq,
    input  n_cs, sclk, have_msg, len, out_data
  );
endinterface

// File: rtl/if_spi_video_rd.sv
// SPI video readout master: clocks N bytes out of the SBIS into a 256x8 buffer,
// then offers them to the encoder as one show-ahead message.
module if_spi_video_rd #(
  parameter int unsigned HALF = 2
) (
  input logic               clk,
  input logic               rst,
  if_spi_video_rd_if.master bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDrain} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic       n_cs_q, n_cs_d;
  logic       sclk_q, sclk_d;
  logic       have_msg_q, have_msg_d;
  logic [7:0] len_q, len_d;
  logic [7:0] out_data_q, out_data_d;
  logic [7:0] mem [256];

  logic half_end, last_bit, last_pop, accept, pop;

  assign half_end = (cnt_q == 8'(HALF - 1));
  assign last_bit = sclk_q && (bit_cnt_q == 3'd7) && (byte_cnt_q == len_q - 8'd1);
  assign last_pop = (rd_ptr_q == len_q - 8'd1);
  assign accept   = bus.in_ena && (bus.in_data != 8'd0) && !have_msg_q;
  assign pop      = bus.enc_rdreq && have_msg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shreg_q     <= '0;
      byte_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      n_cs_q      <= 1'b1;
      sclk_q      <= 1'b0;
      have_msg_q  <= 1'b0;
      len_q       <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shreg_q     <= shreg_d;
      byte_done_q <= byte_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      n_cs_q      <= n_cs_d;
      sclk_q      <= sclk_d;
      have_msg_q  <= have_msg_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
    end
  end

  // Buffer has no reset; only the pointers carry state.
  always_ff @(posedge clk) begin
    if (!rst && byte_done_q) begin
      mem[wr_ptr_q] <= shreg_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StSetup;
      StSetup: if (half_end) state_d = StShift;
      StShift: if (half_end && last_bit) state_d = StHold;
      StHold:  if (half_end) state_d = StDrain;
      StDrain: if (pop && last_pop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = '0;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shreg_d     = shreg_q;
    byte_done_d = 1'b0;
    wr_ptr_d    = byte_done_q ? wr_ptr_q + 8'd1 : wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    n_cs_d      = n_cs_q;
    sclk_d      = sclk_q;
    have_msg_d  = have_msg_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          n_cs_d     = 1'b0;
          len_d      = bus.in_data;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
        end
      end
      StSetup: cnt_d = half_end ? 8'd0 : cnt_q + 8'd1;
      StShift: begin
        cnt_d = half_end ? 8'd0 : cnt_q + 8'd1;
        if (half_end) begin
          if (!sclk_q) begin
            // Sample on the same edge that raises sclk.
            sclk_d      = 1'b1;
            shreg_d     = {shreg_q[6:0], bus.miso};
            byte_done_d = (bit_cnt_q == 3'd7);
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      StHold: begin
        cnt_d = half_end ? 8'd0 : cnt_q + 8'd1;
        if (half_end) begin
          n_cs_d     = 1'b1;
          have_msg_d = 1'b1;
          rd_ptr_d   = '0;
          out_data_d = mem[8'd0];
        end
      end
      StDrain: begin
        if (pop) begin
          if (last_pop) begin
            have_msg_d = 1'b0;
            len_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
          end else begin
            rd_ptr_d   = rd_ptr_q + 8'd1;
            out_data_d = mem[rd_ptr_q + 8'd1];
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.n_cs     = n_cs_q;
  assign bus.sclk     = sclk_q;
  assign bus.have_msg = have_msg_q;
  assign bus.len      = len_q;
  assign bus.out_data = out_data_q;

endmodule

// File: doc/if_spi_video_rd.md
# if_spi_video_rd

SPI video readout master for the SBIS BOS video port (slv/sckv/sdatav). It sits on the slave side of the command path: downstream of `cmd_decoder`, which delivers the read-length command, and upstream of `cmd_encoder`, which drains the captured bytes through the standard `have_msg`/`len`/`out_data`/`rdreq` source interface. One command byte sets how many video bytes to clock out of the SBIS. The block buffers the complete burst, then presents it to the encoder as one message.

## Interface
- `HALF`, default 2: sclk half-period in clk cycles, legal range 1..255; sclk = clk/(2·HALF).
- `clk` in 1: system clock, `fpga_clk_48` domain. The block uses this one clock only.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in 8: command byte from `cmd_decoder` `q`.
- `in_ena` in 1: one-cycle strobe qualifying `in_data` (this block's `valid_bus` bit).
- `n_cs` out 1: SPI chip select to `slv_fpga`, active low.
- `sclk` out 1: SPI clock to `sckv_fpga`, CPOL=0.
- `miso` in 1: SPI data from `sdatav_fpga`, MSB first.
- `have_msg` out 1: a complete captured message is waiting.
- `len` out 8: byte count of the waiting message.
- `out_data` out 8: head byte of the buffer (show-ahead).
- `enc_rdreq` in 1: pop strobe from `cmd_encoder`.

## Operation
- All outputs are registered. Reset values: `n_cs`=1, `sclk`=0, `have_msg`=0, `len`=0, `out_data`=0.
- Reset also clears the 256×8 buffer pointers and returns the FSM to IDLE. This applies mid-transfer too: `n_cs` goes high on the next edge and partial data is discarded.
- Command: `in_ena` with `in_data`=N, where N=1..255, requests an N-byte read.
- N=0 is ignored.
- `in_ena` is ignored in any state other than IDLE, and while `have_msg`=1. There is no queueing.
- FSM states:
  - IDLE: on an accepted command, latch N into `len`, clear the byte counter, drive `n_cs` low, then go to SETUP.
  - SETUP: `n_cs` low with `sclk` low for HALF cycles, then go to SHIFT.
  - SHIFT: each bit is HALF cycles with `sclk` low, then HALF cycles with `sclk` high.
    - `miso` is sampled on the clk edge that drives `sclk` 0→1.
    - Bits shift MSB first into an 8-bit register.
    - After the 8th sample, the byte is written to the buffer on the next clk edge and the write pointer increments.
    - After the Nth byte's high phase ends, `sclk` returns low and the FSM goes to HOLD.
  - HOLD: `n_cs` low with `sclk` low for HALF cycles. Then `n_cs` goes high, `have_msg` goes high, and the FSM goes to DRAIN.
  - DRAIN:
    - `out_data` shows the buffer head.
    - Each `enc_rdreq` pops one byte, and `out_data` updates on the following edge.
    - On the pop of the Nth byte, `have_msg` goes low, pointers reset, and the FSM goes to IDLE.
    - `enc_rdreq` while `have_msg`=0 is ignored: no pointer change and no underflow.
- The buffer never overflows, because N ≤ 255 is less than the depth of 256.
- `len` holds N until the final pop, then clears to 0.

## Timing
- In the cycle after the `in_ena` edge, `n_cs`=0. The first `sclk` rise comes HALF cycles later.
- `n_cs` low duration: HALF·(2 + 16·N) cycles.
- `have_msg` rises in the same cycle that `n_cs` rises.
- Latency from `in_ena` to `have_msg` = 1 + HALF·(2 + 16·N) cycles.
  - Example: HALF=2, N=1 gives 37 cycles.
- Pop latency: `out_data` shows the next byte one cycle after `enc_rdreq`.
- Back-to-back `enc_rdreq` on every cycle is legal.
- `sclk` duty cycle is exactly 50%. There are no glitches on `sclk` or `n_cs`, since both come from registers.
- A write and a read never coincide, because DRAIN and SHIFT are exclusive.

## Test plan
- Basic read: HALF=2, command N=2, slave returns 0xA5 then 0x3C.
  - `n_cs` low for 68 cycles and exactly 16 `sclk` rises.
  - `have_msg`=1 with `len`=2.
  - Two pops give `out_data` 0xA5 then 0x3C.
  - `have_msg`=0 after the 2nd pop.
- Ignored commands:
  - N=0: no `n_cs` activity.
  - A second command during SHIFT: no effect, and `len` is unchanged.
  - A command while `have_msg`=1: no new transfer.
- Long burst: N=255 with an incrementing slave pattern 0x00..0xFE.
  - All 255 bytes are read back in order.
  - Pointers return to IDLE, and a following N=1 read works.
- Reset mid-SHIFT: assert `rst` after 5 bits.
  - The next edge gives `n_cs`=1, `sclk`=0, `have_msg`=0.
  - A subsequent N=1 read of 0x81 returns 0x81.
- Timing and pop edges: HALF=1.
  - `sclk` toggles every cycle.
  - Latency from `in_ena` to `have_msg` is 19 cycles for N=1.
  - `enc_rdreq` asserted with `have_msg`=0 leaves the state unchanged.
